bist_response_analyzer: RTL and testbench

BIST_RESPONSE_ANALYZER -- requirements
Module: bist_response_analyzer

---
 rtl/bist_response_analyzer.sv | 150 +++++++++++++++
 tb/tb_bist_response_analyzer.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/bist_response_analyzer.sv
// bist_response_analyzer
//   Output response analyzer for ALU BIST. Compacts PATTERN_COUNT result beats into
//   a MISR signature, then compares the signature against GOLDEN_SIG.
//
// Ports
//   clk            : clock, all state updates on the rising edge
//   reset          : asynchronous active-low reset
//   start          : begin a session (honoured in IDLE or DONE only)
//   res_valid      : qualifies res_data for one beat
//   res_data       : result word under test
//   busy           : high in COMPACT and COMPARE
//   done           : high in DONE
//   pass           : signature matched golden value, valid while done=1
//   FAULT_DETECTED : fault flag, holds until the next start or reset
//   signature      : current MISR contents
//
// Optional build macro
//   BIST_ORA_TIMEOUT_EN : adds a watchdog that ends COMPACT with a fault after
//                         TIMEOUT consecutive cycles without a beat.

module bist_response_analyzer #(
   parameter int unsigned      WIDTH         = 8,
   parameter int unsigned      PATTERN_COUNT = 255,
   parameter logic [WIDTH-1:0] POLY          = 8'h1D,
   parameter logic [WIDTH-1:0] SEED          = 8'hFF,
   parameter logic [WIDTH-1:0] GOLDEN_SIG    = 8'h00,
   parameter int unsigned      TIMEOUT       = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic             res_valid,
   input  logic [WIDTH-1:0] res_data,
   output logic             busy,
   output logic             done,
   output logic             pass,
   output logic             FAULT_DETECTED,
   output logic [WIDTH-1:0] signature
);

   localparam logic [15:0] PatCnt = 16'(PATTERN_COUNT);

   typedef enum logic [1:0] {
      StIdle,
      StCompact,
      StCompare,
      StDone
   } state_e;

   state_e           state_q, state_d;
   logic [WIDTH-1:0] sig_q, sig_d;
   logic [15:0]      cnt_q, cnt_d;
   logic             pass_q, pass_d;
   logic             fault_q, fault_d;
   logic [WIDTH-1:0] misr_next;

`ifdef BIST_ORA_TIMEOUT_EN
   localparam logic [15:0] WdLast = 16'(TIMEOUT - 1);
   logic [15:0] wd_q, wd_d;
`endif

   // Shift left, fold the outgoing MSB back through POLY, then mix in the new beat.
   assign misr_next = {sig_q[WIDTH-2:0], 1'b0} ^ (sig_q[WIDTH-1] ? POLY : '0) ^ res_data;

   always_comb begin
      state_d = state_q;
      sig_d   = sig_q;
      cnt_d   = cnt_q;
      pass_d  = pass_q;
      fault_d = fault_q;
`ifdef BIST_ORA_TIMEOUT_EN
      wd_d    = wd_q;
`endif
      unique case (state_q)
         StIdle, StDone: begin
            // A beat arriving with start is dropped: the restart wins.
            if (start) begin
               state_d = StCompact;
               sig_d   = SEED;
               cnt_d   = '0;
               pass_d  = 1'b0;
               fault_d = 1'b0;
`ifdef BIST_ORA_TIMEOUT_EN
               wd_d    = '0;
`endif
            end
         end
         StCompact: begin
            if (res_valid) begin
               sig_d = misr_next;
               cnt_d = cnt_q + 16'd1;
`ifdef BIST_ORA_TIMEOUT_EN
               wd_d  = '0;
`endif
               if (cnt_q + 16'd1 == PatCnt) begin
                  state_d = StCompare;
               end
            end
`ifdef BIST_ORA_TIMEOUT_EN
            else if (wd_q == WdLast) begin
               state_d = StDone;
               pass_d  = 1'b0;
               fault_d = 1'b1;
            end else begin
               wd_d = wd_q + 16'd1;
            end
`endif
         end
         StCompare: begin
            pass_d  = (sig_q == GOLDEN_SIG);
            fault_d = (sig_q != GOLDEN_SIG);
            state_d = StDone;
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= StIdle;
         sig_q   <= SEED;
         cnt_q   <= '0;
         pass_q  <= 1'b0;
         fault_q <= 1'b0;
      end else begin
         state_q <= state_d;
         sig_q   <= sig_d;
         cnt_q   <= cnt_d;
         pass_q  <= pass_d;
         fault_q <= fault_d;
      end
   end

`ifdef BIST_ORA_TIMEOUT_EN
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         wd_q <= '0;
      end else begin
         wd_q <= wd_d;
      end
   end
`endif

   assign busy           = (state_q == StCompact) || (state_q == StCompare);
   assign done           = (state_q == StDone);
   assign pass           = pass_q;
   assign FAULT_DETECTED = fault_q;
   assign signature      = sig_q;

endmodule

// File: tb/tb_bist_response_analyzer.sv
// Directed bench for bist_response_analyzer with PATTERN_COUNT=2, GOLDEN_SIG=8'hDB.
module tb_bist_response_analyzer;

   logic       clk = 1'b0;
   logic       reset;
   logic       start;
   logic       res_valid;
   logic [7:0] res_data;
   logic       busy;
   logic       done;
   logic       pass;
   logic       fault;
   logic [7:0] signature;

   int total = 0;
   int bad   = 0;

   bist_response_analyzer #(
      .WIDTH        (8),
      .PATTERN_COUNT(2),
      .POLY         (8'h1D),
      .SEED         (8'hFF),
      .GOLDEN_SIG   (8'hDB),
      .TIMEOUT      (16)
   ) dut (
      .clk           (clk),
      .reset         (reset),
      .start         (start),
      .res_valid     (res_valid),
      .res_data      (res_data),
      .busy          (busy),
      .done          (done),
      .pass          (pass),
      .FAULT_DETECTED(fault),
      .signature     (signature)
   );

   always #5 clk = ~clk;

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_start();
      start = 1'b1;
      tick();
      start = 1'b0;
   endtask

   task automatic beat(input logic [7:0] data);
      res_valid = 1'b1;
      res_data  = data;
      tick();
      res_valid = 1'b0;
      res_data  = 8'h00;
   endtask

   task automatic check_outs(input string tag, input logic b, input logic d, input logic p,
                             input logic f, input logic [7:0] s);
      check_val({tag, ".busy"}, 32'(busy), 32'(b));
      check_val({tag, ".done"}, 32'(done), 32'(d));
      check_val({tag, ".pass"}, 32'(pass), 32'(p));
      check_val({tag, ".fault"}, 32'(fault), 32'(f));
      check_val({tag, ".sig"}, 32'(signature), 32'(s));
   endtask

   initial begin
      reset     = 1'b0;
      start     = 1'b0;
      res_valid = 1'b0;
      res_data  = 8'h00;
      #12;
      check_outs("reset", 1'b0, 1'b0, 1'b0, 1'b0, 8'hFF);
      reset = 1'b1;
      tick();
      tick();
      check_outs("idle_hold", 1'b0, 1'b0, 1'b0, 1'b0, 8'hFF);

      // Pass path: FF -> E3 -> DB.
      do_start();
      check_outs("pass_start", 1'b1, 1'b0, 1'b0, 1'b0, 8'hFF);
      beat(8'h00);
      check_outs("pass_b1", 1'b1, 1'b0, 1'b0, 1'b0, 8'hE3);
      beat(8'h00);
      check_outs("pass_compare", 1'b1, 1'b0, 1'b0, 1'b0, 8'hDB);
      tick();
      check_outs("pass_done", 1'b0, 1'b1, 1'b1, 1'b0, 8'hDB);

      // Stray beats in DONE are ignored.
      res_valid = 1'b1;
      res_data  = 8'h55;
      tick();
      tick();
      res_valid = 1'b0;
      check_outs("done_stray", 1'b0, 1'b1, 1'b1, 1'b0, 8'hDB);

      // Fault path: FF -> E3 -> DA.
      do_start();
      check_outs("fault_start", 1'b1, 1'b0, 1'b0, 1'b0, 8'hFF);
      beat(8'h00);
      beat(8'h01);
      check_val("fault_sig", 32'(signature), 32'h0000_00DA);
      tick();
      check_outs("fault_done", 1'b0, 1'b1, 1'b0, 1'b1, 8'hDA);

      // Back-to-back: restart in DONE with a concurrent beat that must be dropped.
      start     = 1'b1;
      res_valid = 1'b1;
      res_data  = 8'h00;
      tick();
      start     = 1'b0;
      res_valid = 1'b0;
      check_outs("b2b_start", 1'b1, 1'b0, 1'b0, 1'b0, 8'hFF);
      beat(8'h00);
      beat(8'h00);
      tick();
      check_outs("b2b_done", 1'b0, 1'b1, 1'b1, 1'b0, 8'hDB);

      // Gaps plus start pulses inside COMPACT.
      do_start();
      start = 1'b1;
      tick();
      start = 1'b0;
      check_outs("gap_start_ign", 1'b1, 1'b0, 1'b0, 1'b0, 8'hFF);
      beat(8'h00);
      tick();
      tick();
      check_outs("gap_idle", 1'b1, 1'b0, 1'b0, 1'b0, 8'hE3);
      start     = 1'b1;
      res_valid = 1'b1;
      res_data  = 8'h00;
      tick();
      start     = 1'b0;
      res_valid = 1'b0;
      check_val("gap_sig2", 32'(signature), 32'h0000_00DB);
      tick();
      check_outs("gap_done", 1'b0, 1'b1, 1'b1, 1'b0, 8'hDB);

      // Reset mid-session aborts and reports nothing.
      do_start();
      beat(8'h00);
      #2;
      reset = 1'b0;
      #1;
      check_outs("midrst", 1'b0, 1'b0, 1'b0, 1'b0, 8'hFF);
      tick();
      reset = 1'b1;
      tick();
      tick();
      check_outs("midrst_idle", 1'b0, 1'b0, 1'b0, 1'b0, 8'hFF);
      do_start();
      beat(8'h00);
      beat(8'h00);
      tick();
      check_outs("midrst_clean", 1'b0, 1'b1, 1'b1, 1'b0, 8'hDB);

      // Watchdog: one beat, then silence.
      do_start();
      beat(8'h00);
      repeat (15) tick();
      check_outs("wd_15", 1'b1, 1'b0, 1'b0, 1'b0, 8'hE3);
      tick();
`ifdef BIST_ORA_TIMEOUT_EN
      check_outs("wd_16", 1'b0, 1'b1, 1'b0, 1'b1, 8'hE3);
`else
      check_outs("wd_16", 1'b1, 1'b0, 1'b0, 1'b0, 8'hE3);
      repeat (20) tick();
      check_outs("wd_36", 1'b1, 1'b0, 1'b0, 1'b0, 8'hE3);
      beat(8'h00);
      tick();
      check_outs("wd_finish", 1'b0, 1'b1, 1'b1, 1'b0, 8'hDB);
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
